punching_collect: RTL
=====================

Name: punching_collect

Overview:
- Downstream consumer of the hierarchical punching datapath (the a4/b → c path).
- Each cycle it may accept one result bit c, together with the operands a and b that produced it.
- Packs result bits into WIDTH-bit words and emits them on a valid/ready output, with a parity bit and a valid-bit count.
- Checks every bit against the closed-form reference c == (a & b), keeping a saturating mismatch counter and a sticky error flag.

Parameters:
- WIDTH, 8, bits per output word (≥2).
- CNT_W, 16, width of the mismatch counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/result triple present.
- in_ready  out  1  block can accept a triple this cycle.
- in_a  in  1  operand a4 as driven to the punching datapath.
- in_b  in  1  operand b.
- in_c  in  1  result c returned by the punching datapath.
- flush  in  1  emit the partial word.
- out_valid  out  1  out_word/out_parity/out_count valid.
- out_ready  in  1  consumer accepts the word.
- out_word  out  WIDTH  packed results; the first accepted bit is in bit 0.
- out_count  out  $clog2(WIDTH+1)  number of valid bits in out_word (1..WIDTH).
- out_parity  out  1  XOR of the valid bits of out_word.
- err_cnt  out  CNT_W  number of mismatches, saturating.
- err_sticky  out  1  set on first mismatch.

Behaviour:
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid holds, and out_word/out_count/out_parity stay stable, until transfer.
- Reset (asynchronous, any time, including mid-word or while out_valid): all outputs 0, state FILL, fill index 0, accumulator cleared. in_ready is 1 once reset deasserts.
- Storage: a WIDTH-bit accumulator with fill index idx, plus one output register.
- State FILL:
  - in_ready = 1.
  - On accept: acc[idx] = in_c, idx++.
  - When the accepted bit makes idx reach WIDTH, the accumulator hands off.
- Handoff:
  - Condition: the output register is free this cycle (out_valid==0, or transfer this cycle).
  - If free: the next cycle has out_word = acc (including the new bit), out_count = WIDTH, out_valid = 1; acc and idx clear and the block stays in FILL.
  - If not free: go to PEND.
  - Latency: a word is visible on the cycle after its last bit is accepted.
  - Sustained throughput with out_ready held high: 1 bit/cycle.
- State PEND:
  - in_ready = 0.
  - Handoff on the first cycle with an output transfer; return to FILL the next cycle with idx = 0.
  - flush is ignored.
- Flush in FILL:
  - Applies when flush=1 and (idx>0 or accept this cycle).
  - A bit accepted in the same cycle is included.
  - The partial word hands off exactly as a full word, with out_count = bits held.
  - Unused upper bits of out_word are 0.
  - Flush with no bits held and no accept: no effect.
  - A flush coinciding with a WIDTH-completing bit gives a normal full word.
- Parity: computed over the valid bits and registered together with out_word.
- Checker (on every accept):
  - Mismatch = in_c != (in_a & in_b).
  - err_cnt increments, saturating at all-ones.
  - err_sticky sets and clears only on reset.
  - Mismatching bits are still packed unchanged.

Decomposition:
- Shared package punching_pkg holds:
  - the default WIDTH and CNT_W;
  - the state enum {FILL, PEND};
  - a function expected_c(a,b) = a & b.
- Sub-module punching_err_cnt: CNT_W saturating counter with an increment input plus the sticky flag.
- Everything else stays in the top module.

Test Plan:
1. Reset mid-word: accept 3 bits, assert reset → out_valid=0, err_cnt=0, err_sticky=0; the next 8 bits give a fresh word with out_count=8.
2. WIDTH=8, out_ready=1, in_a=in_b=1, c=1 for 8 cycles → one cycle after the 8th accept: out_word=0xFF, out_count=8, out_parity=0, err_cnt=0.
3. Consistent c sequence 1,0,1,1,0,0,0,1 (a&b matched) → out_word=0x8D, out_parity=0, out_count=8.
4. out_ready=0, stream 16 consistent bits → word 1 is held on the output; after the 16th accept, in_ready=0 (PEND). Raising out_ready for one cycle → word 2 appears the next cycle and in_ready=1.
5. Bits c=1,1,0 then flush → out_word=0x03, out_count=3, out_parity=0. Flush again with empty acc → no out_valid.
6. CNT_W=2, four triples a=0,b=1,c=1 → err_sticky=1 after the first, err_cnt=1,2,3,3 (saturates); packed bits are still 1.

Source files
------------

// File: rtl/punching_pkg.sv
// Shared definitions for the punching result collector.
//   DEF_WIDTH / DEF_CNT_W : default word width and mismatch-counter width
//   state_t               : collector state (FILL accepting bits, PEND holding a word)
//   expected_c            : closed-form reference result of the punching datapath
package punching_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  function automatic logic expected_c(input logic a, input logic b);
    return a & b;
  endfunction

endpackage

// File: rtl/punching_err_cnt.sv
// Saturating mismatch counter with sticky error flag.
//   clk, reset : clock and asynchronous active-high reset
//   inc        : count one mismatch this cycle
//   count      : mismatches seen, holds at all-ones
//   sticky     : set on the first mismatch, cleared only by reset
module punching_err_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sticky
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      sticky <= 1'b0;
    end else if (inc) begin
      if (count != '1) count <= count + 1'b1;
      sticky <= 1'b1;
    end
  end

endmodule

// File: rtl/punching_collect.sv
// Collects result bits from the punching datapath into WIDTH-bit words,
// emits them on a valid/ready port with parity and valid-bit count, and
// checks every accepted bit against c == a & b.
//   clk, reset                     : clock, asynchronous active-high reset
//   in_valid/in_ready              : input handshake for one (a, b, c) triple
//   in_a, in_b, in_c               : operands and returned result bit
//   flush                          : emit the partially filled word
//   out_valid/out_ready            : output word handshake
//   out_word, out_count, out_parity: packed bits (first bit in bit 0), count, XOR
//   err_cnt, err_sticky            : saturating mismatch count, sticky error flag
module punching_collect
  import punching_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_a,
  input  logic                       in_b,
  input  logic                       in_c,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_word,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       out_parity,
  output logic [CNT_W-1:0]           err_cnt,
  output logic                       err_sticky
);

  localparam int unsigned IDX_W = $clog2(WIDTH + 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d, acc_in, word_d;
  logic [IDX_W-1:0] idx, idx_d, idx_in, count_d;
  logic             parity_d, valid_d;
  logic             accept, xfer, out_free, mismatch;

  assign in_ready = (state == FILL) & ~reset;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign out_free = ~out_valid | out_ready;
  assign mismatch = accept & (in_c != expected_c(in_a, in_b));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      acc        <= '0;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_count  <= '0;
      out_parity <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      idx        <= idx_d;
      out_valid  <= valid_d;
      out_word   <= word_d;
      out_count  <= count_d;
      out_parity <= parity_d;
    end
  end

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    idx_d    = idx;
    valid_d  = out_valid;
    word_d   = out_word;
    count_d  = out_count;
    parity_d = out_parity;

    // Accumulator and index as they stand after this cycle's accept (if any).
    acc_in = acc;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (accept && (idx == IDX_W'(i))) acc_in[i] = in_c;
    end
    idx_in = idx + IDX_W'(accept);

    if (xfer) valid_d = 1'b0;

    case (state)
      FILL: begin
        acc_d = acc_in;
        idx_d = idx_in;
        // idx_in != 0 covers both "bits already held" and "bit accepted now".
        if ((accept && (idx_in == IDX_W'(WIDTH))) || (flush && (idx_in != '0))) begin
          if (out_free) begin
            valid_d  = 1'b1;
            word_d   = acc_in;
            count_d  = idx_in;
            parity_d = ^acc_in; // unused upper bits are zero
            acc_d    = '0;
            idx_d    = '0;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (xfer) begin
          valid_d  = 1'b1;
          word_d   = acc;
          count_d  = idx;
          parity_d = ^acc;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  punching_err_cnt #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch),
    .count (err_cnt),
    .sticky(err_sticky)
  );

endmodule
